stepped_shifter: RTL and testbench
==================================

// Module: stepped_shifter
// PURPOSE
//   Iterative multi-mode shifter. Generalises the single-bit iterative shifter:
//   - logical, arithmetic or rotate mode
//   - moves up to STEP bits per clock
//   Shift count is advanced and termination detected through the shared external Adder and Comparator.
//   Sits beside the datapath ALU and borrows its adder/comparator while busy.
// PARAMETERS
//   N     8  data width in bits
//   C     8  shift-amount / counter width in bits (amounts >= N are legal)
//   STEP  1  max bits moved per cycle; power of two, 1 <= STEP < N
// PORTS
//   i_clock             in   1  clock, all state on rising edge
//   i_reset             in   1  synchronous, active-high reset
//   i_start             in   1  start request, sampled only in IDLE
//   o_busy              out  1  high in SHIFT and DONE states
//   o_finished          out  1  one-cycle pulse, result valid on o_value
//   i_direction         in   1  0 = left, 1 = right
//   i_mode              in   2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   i_amount            in   C  number of bit positions to shift
//   i_value             in   N  operand
//   o_value             out  N  working/result register
//   o_adder_augend      out  C  r_count
//   o_adder_addend      out  C  chunk (zero-extended)
//   i_adder_sum         in   C  r_count + chunk
//   o_comparator_left   out  C  r_count
//   o_comparator_right  out  C  r_amount
//   i_comparator_equal  in   1  r_count == r_amount
// BEHAVIOUR
//   - Reset: state = IDLE; o_value, r_count, r_amount, o_busy, o_finished = 0; o_carry = 0 when present.
//   - Reset mid-operation aborts with the same values. No o_finished pulse is produced.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE->SHIFT on i_start. That edge latches i_value->o_value, i_amount->r_amount, mode and direction, and clears r_count.
//     SHIFT, i_comparator_equal=1: ->DONE. Value unchanged.
//     SHIFT, otherwise: o_value <= o_value shifted by chunk; r_count <= i_adder_sum; stay in SHIFT.
//     DONE: o_finished=1 for exactly this cycle, ->IDLE.
//   - i_start while o_busy=1 is ignored. Operand inputs are don't-care after the latching edge.
//   - chunk = STEP when (r_amount - r_count) >= STEP (local C-bit subtract), else 1.
//   - Fill rules, per bit moved:
//     logical: zero fill.
//     arithmetic right: copies the MSB. Arithmetic left is identical to logical left.
//     rotate: expelled bits re-enter at the opposite end.
//   - Amounts >= N saturate naturally:
//     logical -> 0; arithmetic right -> all copies of the sign bit; rotate -> effective amount mod N.
//   - Latency: k = amount, s = floor(k/STEP) + (k mod STEP) shift cycles.
//     o_finished is high in the cycle after edge s+1, counting the i_start sampling edge as edge 0.
//     k=0 gives a pulse after edge 1 with the value unchanged.
//   - o_value holds the result from DONE until the next accepted start.
//   - Adder/comparator outputs are driven continuously from r_count, chunk and r_amount (combinational). Their inputs are only used in SHIFT.
// CONFIGURATION
//   STEPPED_SHIFTER_CARRY_EN defined:
//     - Adds port o_carry (out, 1).
//     - Holds the last bit expelled (logical/arithmetic) or wrapped (rotate) by the most recent shift cycle. For chunk > 1 it is the innermost expelled bit.
//     - Cleared to 0 on an accepted start and on reset; unchanged for amount 0.
//   STEPPED_SHIFTER_CARRY_EN undefined: port and register absent, otherwise identical.
// TESTING
//   - N=8, STEP=1, logical left 0x81 by 3 -> o_value=0x08; o_finished after edge 4; o_carry=0.
//   - N=8, STEP=1, arithmetic right 0x90 by 2 -> 0xE4; arithmetic right 0x80 by 12 -> 0xFF; logical right 0xFF by 12 -> 0x00.
//   - N=8, STEP=2, rotate right 0x01 by 9 -> 0x80; 5 shift cycles (2,2,2,2,1); o_finished after edge 6.
//   - Amount 0, value 0x5A -> 0x5A, o_finished after edge 1. A second i_start held high while busy -> no restart, one pulse only.
//   - i_reset asserted 2 cycles into a shift by 7 -> next cycle o_value=0, o_busy=0, no o_finished pulse. A fresh start then completes normally.
//   - With STEPPED_SHIFTER_CARRY_EN: N=8, STEP=1, logical right 0x03 by 1 -> 0x01, o_carry=1.

Source files
------------

// File: rtl/stepped_shifter_if.sv
// Operand, status and borrowed adder/comparator signals of stepped_shifter.
// o_carry exists only when STEPPED_SHIFTER_CARRY_EN is defined.
interface stepped_shifter_if #(
   parameter int N = 8,
   parameter int C = 8
);
   logic         i_start;
   logic         o_busy;
   logic         o_finished;
   logic         i_direction;
   logic [1:0]   i_mode;
   logic [C-1:0] i_amount;
   logic [N-1:0] i_value;
   logic [N-1:0] o_value;
   logic [C-1:0] o_adder_augend;
   logic [C-1:0] o_adder_addend;
   logic [C-1:0] i_adder_sum;
   logic [C-1:0] o_comparator_left;
   logic [C-1:0] o_comparator_right;
   logic         i_comparator_equal;
`ifdef STEPPED_SHIFTER_CARRY_EN
   logic         o_carry;
`endif

   modport slave (
`ifdef STEPPED_SHIFTER_CARRY_EN
      output o_carry,
`endif
      input  i_start, i_direction, i_mode, i_amount, i_value,
      input  i_adder_sum, i_comparator_equal,
      output o_busy, o_finished, o_value,
      output o_adder_augend, o_adder_addend,
      output o_comparator_left, o_comparator_right
   );

   modport master (
`ifdef STEPPED_SHIFTER_CARRY_EN
      input  o_carry,
`endif
      output i_start, i_direction, i_mode, i_amount, i_value,
      output i_adder_sum, i_comparator_equal,
      input  o_busy, o_finished, o_value,
      input  o_adder_augend, o_adder_addend,
      input  o_comparator_left, o_comparator_right
   );
endinterface

// File: rtl/stepped_shifter.sv
// Iterative logical/arithmetic/rotate shifter moving up to STEP bits per clock,
// using an external adder/comparator. STEPPED_SHIFTER_CARRY_EN adds o_carry.
//
// state | meaning
// IDLE  | waiting for i_start; result held on o_value
// SHIFT | shifting by chunk each cycle until count reaches amount
// DONE  | one-cycle o_finished pulse, then back to IDLE
module stepped_shifter #(
   parameter int N    = 8,
   parameter int C    = 8,
   parameter int STEP = 1
) (
   input logic            i_clock,
   input logic            i_reset,
   stepped_shifter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [C-1:0] STEP_C = C'(STEP);
   localparam logic [C-1:0] ONE_C  = C'(1);

   state_t       state_q, state_d;
   logic [N-1:0] value_q;
   logic [C-1:0] count_q;
   logic [C-1:0] amount_q;
   logic         dir_q;
   logic [1:0]   mode_q;
   logic [C-1:0] remaining;
   logic [C-1:0] chunk;
   logic [N-1:0] sh_val;
`ifdef STEPPED_SHIFTER_CARRY_EN
   logic         carry_q;
   logic         sh_cy;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.i_start) state_d = SHIFT;
         SHIFT:   if (bus.i_comparator_equal) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign remaining = amount_q - count_q;
   assign chunk     = (remaining >= STEP_C) ? STEP_C : ONE_C;

   // Unrolled single-bit steps; the last one applied leaves the innermost expelled bit.
   always_comb begin
      sh_val = value_q;
`ifdef STEPPED_SHIFTER_CARRY_EN
      sh_cy  = 1'b0;
`endif
      for (int i = 0; i < STEP; i++) begin
         if (i < int'(chunk)) begin
`ifdef STEPPED_SHIFTER_CARRY_EN
            sh_cy = dir_q ? sh_val[0] : sh_val[N-1];
`endif
            if (dir_q) begin
               case (mode_q)
                  2'b01:   sh_val = {sh_val[N-1], sh_val[N-1:1]};
                  2'b10:   sh_val = {sh_val[0], sh_val[N-1:1]};
                  default: sh_val = {1'b0, sh_val[N-1:1]};
               endcase
            end else begin
               if (mode_q == 2'b10) sh_val = {sh_val[N-2:0], sh_val[N-1]};
               else                 sh_val = {sh_val[N-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         value_q  <= '0;
         count_q  <= '0;
         amount_q <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 2'b00;
`ifdef STEPPED_SHIFTER_CARRY_EN
         carry_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_start) begin
                  value_q  <= bus.i_value;
                  amount_q <= bus.i_amount;
                  count_q  <= '0;
                  dir_q    <= bus.i_direction;
                  mode_q   <= bus.i_mode;
`ifdef STEPPED_SHIFTER_CARRY_EN
                  carry_q  <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (!bus.i_comparator_equal) begin
                  value_q <= sh_val;
                  count_q <= bus.i_adder_sum;
`ifdef STEPPED_SHIFTER_CARRY_EN
                  carry_q <= sh_cy;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_value            = value_q;
   assign bus.o_busy             = (state_q != IDLE);
   assign bus.o_finished         = (state_q == DONE);
   assign bus.o_adder_augend     = count_q;
   assign bus.o_adder_addend     = chunk;
   assign bus.o_comparator_left  = count_q;
   assign bus.o_comparator_right = amount_q;
`ifdef STEPPED_SHIFTER_CARRY_EN
   assign bus.o_carry            = carry_q;
`endif

endmodule

// File: tb/tb_stepped_shifter.sv
// Scoreboard bench for stepped_shifter: STEP=1 and STEP=2 instances run the same
// operations side by side against a bit-at-a-time reference model.
module tb_stepped_shifter;

   localparam int LIMIT = 600;

   typedef struct {
      logic [7:0] val;
      logic       cy;
      int         lat;
   } exp_t;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;
   logic       start   = 1'b0;
   logic       dir     = 1'b0;
   logic [1:0] mode    = 2'b00;
   logic [7:0] amount  = 8'd0;
   logic [7:0] value   = 8'd0;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk_sys = ~clk_sys;

   stepped_shifter_if #(.N(8), .C(8)) if1 ();
   stepped_shifter_if #(.N(8), .C(8)) if2 ();

   assign if1.i_start = start;      assign if2.i_start = start;
   assign if1.i_direction = dir;    assign if2.i_direction = dir;
   assign if1.i_mode = mode;        assign if2.i_mode = mode;
   assign if1.i_amount = amount;    assign if2.i_amount = amount;
   assign if1.i_value = value;      assign if2.i_value = value;
   assign if1.i_adder_sum = if1.o_adder_augend + if1.o_adder_addend;
   assign if2.i_adder_sum = if2.o_adder_augend + if2.o_adder_addend;
   assign if1.i_comparator_equal = (if1.o_comparator_left == if1.o_comparator_right);
   assign if2.i_comparator_equal = (if2.o_comparator_left == if2.o_comparator_right);

   stepped_shifter #(.N(8), .C(8), .STEP(1)) u_dut1 (
      .i_clock (clk_sys),
      .i_reset (rst),
      .bus     (if1.slave)
   );

   stepped_shifter #(.N(8), .C(8), .STEP(2)) u_dut2 (
      .i_clock (clk_sys),
      .i_reset (rst),
      .bus     (if2.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: one bit per iteration, carry = last bit pushed out.
   function automatic logic [8:0] model(input logic [7:0] v, input int amt,
                                        input logic d, input logic [1:0] m);
      logic [7:0] r;
      logic       cy;
      r  = v;
      cy = 1'b0;
      for (int i = 0; i < amt; i++) begin
         if (d) begin
            cy = r[0];
            if (m == 2'b01)      r = {r[7], r[7:1]};
            else if (m == 2'b10) r = {r[0], r[7:1]};
            else                 r = {1'b0, r[7:1]};
         end else begin
            cy = r[7];
            if (m == 2'b10) r = {r[6:0], r[7]};
            else            r = {r[6:0], 1'b0};
         end
      end
      return {cy, r};
   endfunction

   task automatic run_op(input logic [7:0] v, input logic [7:0] amt, input logic d,
                         input logic [1:0] m, input bit hold);
      exp_t       e;
      logic [8:0] r;
      int         a, fin1, fin2;
      logic [7:0] res;
      a = int'(amt);
      @(negedge clk_sys);
      start = 1'b1; value = v; amount = amt; dir = d; mode = m;
      r = model(v, a, d, m);
      res = r[7:0];
      e.val = r[7:0]; e.cy = r[8];
      e.lat = a + 1;                 q1.push_back(e);
      e.lat = a / 2 + a % 2 + 1;     q2.push_back(e);
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (!hold) start = 1'b0;
      value = 8'($urandom); amount = 8'($urandom); dir = 1'($urandom); mode = 2'($urandom);
      fin1 = 0; fin2 = 0;
      for (int edge_n = 1; edge_n <= LIMIT; edge_n++) begin
         @(posedge clk_sys);
         @(negedge clk_sys);
         if (if1.o_finished) begin
            if (q1.size() == 0) chk("dut1_spurious_pulse", 32'd1, 32'd0);
            else begin
               e = q1.pop_front();
               chk("dut1_latency", edge_n, e.lat);
               chk("dut1_value", {24'd0, if1.o_value}, {24'd0, e.val});
               chk("dut1_busy_in_done", {31'd0, if1.o_busy}, 32'd1);
`ifdef STEPPED_SHIFTER_CARRY_EN
               chk("dut1_carry", {31'd0, if1.o_carry}, {31'd0, e.cy});
`endif
               fin1 = edge_n;
            end
         end
         if (if2.o_finished) begin
            if (q2.size() == 0) chk("dut2_spurious_pulse", 32'd1, 32'd0);
            else begin
               e = q2.pop_front();
               chk("dut2_latency", edge_n, e.lat);
               chk("dut2_value", {24'd0, if2.o_value}, {24'd0, e.val});
               chk("dut2_busy_in_done", {31'd0, if2.o_busy}, 32'd1);
`ifdef STEPPED_SHIFTER_CARRY_EN
               chk("dut2_carry", {31'd0, if2.o_carry}, {31'd0, e.cy});
`endif
               fin2 = edge_n;
            end
         end
         if (if1.o_finished || if2.o_finished) start = 1'b0;
         if (fin1 != 0 && fin2 != 0 && edge_n >= fin1 + 3 && edge_n >= fin2 + 3) break;
      end
      if (fin1 == 0 || fin2 == 0) begin
         chk("finish_timeout_dut1", {31'd0, fin1 != 0}, 32'd1);
         chk("finish_timeout_dut2", {31'd0, fin2 != 0}, 32'd1);
         q1.delete(); q2.delete();
      end else begin
         chk("dut1_result_held", {24'd0, if1.o_value}, {24'd0, res});
         chk("dut2_result_held", {24'd0, if2.o_value}, {24'd0, res});
         chk("dut1_idle_after", {31'd0, if1.o_busy}, 32'd0);
         chk("dut2_idle_after", {31'd0, if2.o_busy}, 32'd0);
      end
   endtask

   initial begin
      int any_fin;
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b0;
      chk("reset_value1", {24'd0, if1.o_value}, 32'd0);
      chk("reset_value2", {24'd0, if2.o_value}, 32'd0);
      chk("reset_busy1", {31'd0, if1.o_busy}, 32'd0);
      chk("reset_finished2", {31'd0, if2.o_finished}, 32'd0);
`ifdef STEPPED_SHIFTER_CARRY_EN
      chk("reset_carry1", {31'd0, if1.o_carry}, 32'd0);
`endif

      run_op(8'h81, 8'd3,  1'b0, 2'b00, 1'b0);
      run_op(8'h90, 8'd2,  1'b1, 2'b01, 1'b0);
      run_op(8'h80, 8'd12, 1'b1, 2'b01, 1'b0);
      run_op(8'hFF, 8'd12, 1'b1, 2'b00, 1'b0);
      run_op(8'h01, 8'd9,  1'b1, 2'b10, 1'b0);
      run_op(8'h5A, 8'd0,  1'b0, 2'b00, 1'b1);
      run_op(8'h96, 8'd3,  1'b0, 2'b10, 1'b1);
      run_op(8'h03, 8'd1,  1'b1, 2'b00, 1'b0);
      run_op(8'hC3, 8'd5,  1'b0, 2'b01, 1'b0);
      run_op(8'hA7, 8'd4,  1'b1, 2'b11, 1'b0);
      run_op(8'h6D, 8'd255, 1'b0, 2'b10, 1'b0);

      // Abort a shift by 7 with reset two cycles in.
      @(negedge clk_sys);
      start = 1'b1; value = 8'hA5; amount = 8'd7; dir = 1'b0; mode = 2'b00;
      @(posedge clk_sys);
      @(negedge clk_sys);
      start = 1'b0;
      @(posedge clk_sys);
      @(posedge clk_sys);
      @(negedge clk_sys);
      rst = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("abort_value1", {24'd0, if1.o_value}, 32'd0);
      chk("abort_value2", {24'd0, if2.o_value}, 32'd0);
      chk("abort_busy1", {31'd0, if1.o_busy}, 32'd0);
      chk("abort_busy2", {31'd0, if2.o_busy}, 32'd0);
      rst = 1'b0;
      any_fin = 0;
      for (int i = 0; i < 10; i++) begin
         if (if1.o_finished || if2.o_finished) any_fin = 1;
         @(negedge clk_sys);
      end
      chk("abort_no_pulse", any_fin, 32'd0);
      run_op(8'hA5, 8'd7, 1'b0, 2'b00, 1'b0);

      for (int i = 0; i < 20; i++)
         run_op(8'($urandom), 8'($urandom_range(0, 20)), 1'($urandom), 2'($urandom), 1'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
